// File: rtl/config_spi_deser_if.sv
// Output handshake bundle between the SPI deserializer and the config register.
// The master drives the assembled frame and its valid flag; the slave returns ready.
interface config_spi_deser_if #(
  parameter int MSG_W = 13
);
  logic [MSG_W-1:0] send_msg;
  logic             send_val;
  logic             send_rdy;

  modport master (
    output send_msg,
    output send_val,
    input  send_rdy
  );

  modport slave (
    input  send_msg,
    input  send_val,
    output send_rdy
  );
endinterface

// File: rtl/config_spi_deser.sv
// Config SPI deserializer: synchronizes a 3-wire serial link (cs_n, sclk, mosi),
// assembles MSB-first frames {addr, wr_en, payload} and presents them over a
// val/rdy handshake with sticky overflow and short-frame error flags.
module config_spi_deser #(
  parameter int addr_size    = 4,
  parameter int payload_size = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs_n,
  input  logic                sclk,
  input  logic                mosi,
  input  logic                err_clear,
  output logic                ovf_err,
  output logic                short_err,
  config_spi_deser_if.master  bus
);

  localparam int MSG_W = addr_size + payload_size + 1;
  localparam int CNT_W = $clog2(MSG_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MSG_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Two-flop synchronizers plus one delay stage on sclk for edge detection
  logic cs_meta_r, cs_sync_r;
  logic sclk_meta_r, sclk_sync_r, sclk_dly_r;
  logic mosi_meta_r, mosi_sync_r;
  logic rise_s;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic [MSG_W-1:0] shreg_r, shreg_nxt_s;
  logic [MSG_W-1:0] frame_s;
  logic [MSG_W-1:0] send_msg_r, msg_nxt_s;
  logic             send_val_r, val_nxt_s;
  logic             ovf_err_r, ovf_nxt_s, ovf_set_s;
  logic             short_err_r, short_nxt_s, short_set_s;

  // Bring the asynchronous serial pins into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_dly_r  <= 1'b0;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
    end else begin
      cs_meta_r   <= cs_n;
      cs_sync_r   <= cs_meta_r;
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_dly_r  <= sclk_sync_r;
      mosi_meta_r <= mosi;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  assign rise_s  = sclk_sync_r & ~sclk_dly_r;
  assign frame_s = {shreg_r[MSG_W-2:0], mosi_sync_r};

  // Frame FSM next-state, shift/count update, load/drop decision and error sets
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    shreg_nxt_s = shreg_r;
    msg_nxt_s   = send_msg_r;
    // An accepted frame leaves send_val low unless a new frame reloads it below
    val_nxt_s   = send_val_r & ~bus.send_rdy;
    ovf_set_s   = 1'b0;
    short_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!cs_sync_r) begin
          state_nxt_s = ST_SHIFT;
          count_nxt_s = '0;
          shreg_nxt_s = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_sync_r) begin
          // Chip select released before a full frame: discard it
          short_set_s = 1'b1;
          state_nxt_s = ST_IDLE;
          count_nxt_s = '0;
          shreg_nxt_s = '0;
        end else if (rise_s) begin
          shreg_nxt_s = frame_s;
          if (count_r == LAST_CNT) begin
            count_nxt_s = FULL_CNT;
            state_nxt_s = ST_DRAIN;
            if (!send_val_r || bus.send_rdy) begin
              msg_nxt_s = frame_s;
              val_nxt_s = 1'b1;
            end else begin
              ovf_set_s = 1'b1;
            end
          end else begin
            count_nxt_s = count_r + CNT_W'(1);
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DRAIN: begin
        // Surplus bits after a complete frame are silently ignored
        if (cs_sync_r) begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = '0;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = '0;
        shreg_nxt_s = '0;
      end
    endcase
    // A new error in the same cycle as err_clear takes priority
    ovf_nxt_s   = ovf_set_s   | (ovf_err_r   & ~err_clear);
    short_nxt_s = short_set_s | (short_err_r & ~err_clear);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      shreg_r     <= '0;
      send_msg_r  <= '0;
      send_val_r  <= 1'b0;
      ovf_err_r   <= 1'b0;
      short_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      shreg_r     <= shreg_nxt_s;
      send_msg_r  <= msg_nxt_s;
      send_val_r  <= val_nxt_s;
      ovf_err_r   <= ovf_nxt_s;
      short_err_r <= short_nxt_s;
    end
  end

  assign bus.send_msg = send_msg_r;
  assign bus.send_val = send_val_r;
  assign ovf_err      = ovf_err_r;
  assign short_err    = short_err_r;

endmodule

// File: tb/tb_config_spi_deser.sv
// Directed bench for config_spi_deser: drives serial frames, keeps expected
// frames in a scoreboard queue and checks every handshake transfer against it.
module tb_config_spi_deser;

  localparam int MSG_W = 13;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cs_n = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic err_clear = 1'b0;
  logic ovf_err;
  logic short_err;

  int errors = 0;
  int checks = 0;

  logic [MSG_W-1:0] exp_q[$];

  logic             prev_val = 1'b0;
  logic             prev_rdy = 1'b0;
  logic [MSG_W-1:0] prev_msg = '0;

  config_spi_deser_if #(.MSG_W(MSG_W)) bus ();

  config_spi_deser #(.addr_size(4), .payload_size(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .err_clear (err_clear),
    .ovf_err   (ovf_err),
    .short_err (short_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shift out n bits of v, MSB first; cs_n is released only when raise_cs is set
  task automatic send_bits(input logic [15:0] v, input int n, input bit raise_cs);
    cs_n = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    if (raise_cs) begin
      tick(4);
      cs_n = 1'b1;
      tick(6);
    end
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    check(tag, 16'(exp_q.size()), 16'd0);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_val && !prev_rdy && bus.send_val)
        check("msg_stable", 16'(bus.send_msg), 16'(prev_msg));
      if (bus.send_val && bus.send_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 16'(bus.send_msg), 16'hFFFF);
        end else begin
          logic [MSG_W-1:0] e;
          e = exp_q.pop_front();
          check("xfer_data", 16'(bus.send_msg), 16'(e));
        end
      end
    end
    prev_val = bus.send_val;
    prev_rdy = bus.send_rdy;
    prev_msg = bus.send_msg;
  end

  initial begin
    bus.send_rdy = 1'b0;

    // Reset held with cs_n low and sclk toggling
    reset = 1'b1;
    cs_n  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sclk = ~sclk;
      tick(1);
    end
    check("rst_val",   16'(bus.send_val), 16'd0);
    check("rst_msg",   16'(bus.send_msg), 16'd0);
    check("rst_ovf",   16'(ovf_err),      16'd0);
    check("rst_short", 16'(short_err),    16'd0);
    cs_n = 1'b1;
    sclk = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(4);
    check("idle_val", 16'(bus.send_val), 16'd0);

    // Single frame with downstream ready
    bus.send_rdy = 1'b1;
    exp_q.push_back(13'h0155);
    send_bits(16'h0155, 13, 1'b1);
    wait_drain("single_drain");
    check("single_ovf",   16'(ovf_err),   16'd0);
    check("single_short", 16'(short_err), 16'd0);
    check("single_val_low", 16'(bus.send_val), 16'd0);

    // Back-to-back frames
    exp_q.push_back(13'h0155);
    send_bits(16'h0155, 13, 1'b1);
    exp_q.push_back(13'h0AAA);
    send_bits(16'h0AAA, 13, 1'b1);
    wait_drain("b2b_drain");
    check("b2b_ovf", 16'(ovf_err), 16'd0);

    // Backpressure: second frame dropped while the first is pending
    bus.send_rdy = 1'b0;
    exp_q.push_back(13'h0155);
    send_bits(16'h0155, 13, 1'b1);
    send_bits(16'h1FFF, 13, 1'b1);
    check("bp_val", 16'(bus.send_val), 16'd1);
    check("bp_msg", 16'(bus.send_msg), 16'h0155);
    check("bp_ovf", 16'(ovf_err),      16'd1);
    bus.send_rdy = 1'b1;
    wait_drain("bp_drain");
    tick(3);
    check("bp_val_low", 16'(bus.send_val), 16'd0);
    check("bp_ovf_hold", 16'(ovf_err), 16'd1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(1);
    check("ovf_cleared", 16'(ovf_err), 16'd0);

    // Short frame: cs_n released after 7 bits
    send_bits(16'h005A, 7, 1'b1);
    tick(2);
    check("short_set", 16'(short_err),    16'd1);
    check("short_val", 16'(bus.send_val), 16'd0);

    // Long frame: 15 bits, only the first 13 form the message
    exp_q.push_back(13'h0A55);
    send_bits({1'b0, 13'h0A55, 2'b11}, 15, 1'b1);
    wait_drain("long_drain");
    check("long_short_hold", 16'(short_err), 16'd1);
    check("long_ovf", 16'(ovf_err), 16'd0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(1);
    check("short_cleared", 16'(short_err), 16'd0);

    // Same-cycle accept and load
    bus.send_rdy = 1'b0;
    exp_q.push_back(13'h1234);
    send_bits(16'h1234, 13, 1'b1);
    check("sc_pending", 16'(bus.send_val), 16'd1);
    exp_q.push_back(13'h0BCD);
    send_bits(16'h0BCD >> 1, 12, 1'b0);
    mosi = 1'b1;
    tick(4);
    sclk = 1'b1;
    // Final bit completes two posedges after the sync chain sees sclk high
    tick(2);
    bus.send_rdy = 1'b1;
    tick(1);
    bus.send_rdy = 1'b0;
    check("sc_val",  16'(bus.send_val), 16'd1);
    check("sc_msg",  16'(bus.send_msg), 16'h0BCD);
    check("sc_ovf",  16'(ovf_err),      16'd0);
    check("sc_qlen", 16'(exp_q.size()), 16'd1);
    tick(2);
    sclk = 1'b0;
    tick(4);
    cs_n = 1'b1;
    tick(6);
    bus.send_rdy = 1'b1;
    wait_drain("sc_drain");
    tick(3);
    check("sc_val_low", 16'(bus.send_val), 16'd0);
    check("sc_ovf_end", 16'(ovf_err), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
